// File: rtl/weight_arb_pkg.sv
// Shared types and constants for the weight SRAM arbiter.
// Addressing, data width and master index assignments for the EPU weight store.
package weight_arb_pkg;

   typedef enum logic {
      ARB   = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

   localparam int WSRAM_ADDR_W    = 17;
   localparam int WSRAM_DATA_W    = 18;
   localparam int WSRAM_POP_WORDS = 32768;

   localparam int M_DMA = 0;
   localparam int M_PE  = 1;
   localparam int M_DBG = 2;

endpackage

// File: rtl/weight_sram_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of valid at or above ptr, with wrap.
// Purely combinational; one-hot grant plus its binary index, all-zero when nothing is valid.
module rr_pick #(
   parameter int N     = 3,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx
);

   logic found;
   int   slot;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      slot  = 0;
      for (int k = 0; k < N; k++) begin
         slot = (int'(ptr) + k) % N;
         if (!found && valid[slot]) begin
            found       = 1'b1;
            grant[slot] = 1'b1;
            idx         = IDX_W'(slot);
         end
      end
   end

endmodule

// File: rtl/weight_sram_arbiter.sv
// Round-robin arbiter sharing the single-port weight SRAM, with burst lock, burst cap and idle timeout.
// Grant is same-cycle combinational; reads return exactly one cycle after acceptance.
// Backpressure: only the granted master sees req_ready; all others stall until their turn.
module weight_sram_arbiter
   import weight_arb_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = WSRAM_ADDR_W,
   parameter int DATA_W    = WSRAM_DATA_W,
   parameter int POP_WORDS = WSRAM_POP_WORDS,
   parameter int MAX_BURST = 16,
   parameter int LOCK_TO   = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ-1:0]          req_write,
   input  logic [NUM_REQ-1:0]          req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic                        rsp_err,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic                        sram_cs,
   output logic                        sram_oe,
   output logic                        sram_web,
   output logic [ADDR_W-1:0]           sram_addr,
   output logic [DATA_W-1:0]           sram_wdata,
   input  logic [DATA_W-1:0]           sram_rdata
);

   localparam int IDX_W   = $clog2(NUM_REQ);
   localparam int CNT_MAX = (MAX_BURST > LOCK_TO) ? MAX_BURST : LOCK_TO;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [ADDR_W:0] POP_LIM = (ADDR_W + 1)'(POP_WORDS);

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    owner_q, owner_d, rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    burst_q, burst_d, idle_q, idle_d;
   logic [NUM_REQ-1:0]  pick_grant, grant;
   logic [IDX_W-1:0]    pick_idx, g;
   logic                beat, write_g, lock_g, in_range, release_lock;
   logic [ADDR_W-1:0]   addr_g, addr_q;
   logic [DATA_W-1:0]   wdata_g, wdata_q;
   logic                rd_pend_q, rd_oor_q;
   logic [IDX_W-1:0]    rd_src_q;

   rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .valid (req_valid),
      .ptr   (rr_ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   // Ready is masked during reset so no master sees a grant while rst_n is low.
   always_comb begin
      grant = '0;
      g     = pick_idx;
      if (state_q == ARB) begin
         grant = pick_grant;
      end else begin
         g              = owner_q;
         grant[owner_q] = req_valid[owner_q];
      end
      if (!rst_n) grant = '0;
   end

   assign req_ready = grant;
   assign beat      = |grant;
   assign addr_g    = req_addr[g*ADDR_W +: ADDR_W];
   assign wdata_g   = req_wdata[g*DATA_W +: DATA_W];
   assign write_g   = req_write[g];
   assign lock_g    = req_lock[g];
   assign in_range  = {1'b0, addr_g} < POP_LIM;

   assign sram_cs    = beat & in_range;
   assign sram_web   = ~(beat & in_range & write_g);
   assign sram_addr  = beat ? addr_g : addr_q;
   assign sram_wdata = beat ? wdata_g : wdata_q;

   assign sram_oe   = rd_pend_q & ~rd_oor_q;
   assign rsp_err   = rd_pend_q & rd_oor_q;
   assign rsp_rdata = sram_oe ? sram_rdata : '0;

   always_comb begin
      rsp_valid = '0;
      if (rd_pend_q) rsp_valid[rd_src_q] = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      burst_d      = burst_q;
      idle_d       = idle_q;
      rr_ptr_d     = rr_ptr_q;
      release_lock = 1'b0;
      unique case (state_q)
         ARB: begin
            if (beat) begin
               rr_ptr_d = next_idx(g);
               if (lock_g && MAX_BURST > 1) begin
                  state_d = OWNED;
                  owner_d = g;
                  burst_d = CNT_W'(1);
                  idle_d  = '0;
               end
            end
         end
         OWNED: begin
            // In OWNED a beat can only come from the owner.
            if (beat) begin
               burst_d      = sat_inc(burst_q);
               idle_d       = '0;
               release_lock = !lock_g || (burst_q >= CNT_W'(MAX_BURST - 1));
            end else begin
               idle_d       = sat_inc(idle_q);
               release_lock = idle_q >= CNT_W'(LOCK_TO - 1);
            end
            if (release_lock) begin
               state_d  = ARB;
               rr_ptr_d = next_idx(owner_q);
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB;
         owner_q   <= '0;
         rr_ptr_q  <= '0;
         burst_q   <= '0;
         idle_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_pend_q <= 1'b0;
         rd_src_q  <= '0;
         rd_oor_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
         burst_q   <= burst_d;
         idle_q    <= idle_d;
         rd_pend_q <= beat & ~write_g;
         rd_src_q  <= g;
         rd_oor_q  <= ~in_range;
         if (beat) begin
            addr_q  <= addr_g;
            wdata_q <= wdata_g;
         end
      end
   end

endmodule

// File: tb/tb_weight_sram_arbiter.sv
// Scoreboard bench for weight_sram_arbiter: random and directed traffic from three masters,
// checked cycle by cycle against a transaction-level arbitration and memory model.
module tb_weight_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  v, wr, lk;
   logic [16:0] a [3];
   logic [17:0] wd [3];
   logic [2:0]  req_ready, rsp_valid;
   logic [50:0] req_addr;
   logic [53:0] req_wdata;
   logic        rsp_err, sram_cs, sram_oe, sram_web;
   logic [17:0] rsp_rdata, sram_wdata, sram_rdata;
   logic [16:0] sram_addr;

   assign req_addr  = {a[2], a[1], a[0]};
   assign req_wdata = {wd[2], wd[1], wd[0]};

   always #5 clk = ~clk;

   weight_sram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v), .req_ready(req_ready), .req_write(wr), .req_lock(lk),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // Behavioural single-port SRAM, one-cycle read latency.
   logic [17:0] sram_mem [32768];
   logic [17:0] ref_mem  [32768];
   logic [17:0] sram_rd = '0;
   assign sram_rdata = sram_rd;

   always @(posedge clk) begin
      if (sram_cs) begin
         if (!sram_web) sram_mem[sram_addr[14:0]] <= sram_wdata;
         else           sram_rd <= sram_mem[sram_addr[14:0]];
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   typedef struct {
      int          src;
      bit          err;
      logic [17:0] data;
      int          due;
   } rsp_t;

   rsp_t        expq [$];
   int          cyc = 0;
   int          owner = -1, ptr = 0, beats = 0, idle = 0;
   logic [16:0] last_addr = '0;
   logic [17:0] last_wdata = '0;
   int          eg;
   bit          inr;
   rsp_t        e;

   // Reference model: state is kept as "owner or nobody", a rotating start index and two plain counts.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("rst_ready", req_ready, 0);
         chk("rst_cs", sram_cs, 0);
         chk("rst_web", sram_web, 1);
         chk("rst_oe", sram_oe, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_err", rsp_err, 0);
         chk("rst_rsp_rdata", rsp_rdata, 0);
         chk("rst_addr", sram_addr, 0);
         owner = -1; ptr = 0; beats = 0; idle = 0;
         last_addr = '0; last_wdata = '0;
         expq.delete();
      end else begin
         if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            chk("rsp_valid", rsp_valid, 64'(1) << e.src);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_rdata", rsp_rdata, e.data);
            chk("sram_oe", sram_oe, !e.err);
         end else begin
            chk("rsp_idle", rsp_valid, 0);
            chk("oe_idle", sram_oe, 0);
         end

         eg = -1;
         if (owner >= 0) begin
            if (v[owner]) eg = owner;
         end else begin
            for (int k = 0; k < 3; k++)
               if (eg < 0 && v[(ptr + k) % 3]) eg = (ptr + k) % 3;
         end
         chk("grant", req_ready, (eg >= 0) ? (64'(1) << eg) : 64'(0));

         if (eg >= 0) begin
            inr = a[eg] < 17'd32768;
            chk("beat_cs", sram_cs, inr);
            chk("beat_web", sram_web, (inr && wr[eg]) ? 0 : 1);
            chk("beat_addr", sram_addr, a[eg]);
            chk("beat_wdata", sram_wdata, wd[eg]);
            last_addr  = a[eg];
            last_wdata = wd[eg];
            if (wr[eg]) begin
               if (inr) ref_mem[a[eg][14:0]] = wd[eg];
            end else begin
               expq.push_back('{eg, !inr, inr ? ref_mem[a[eg][14:0]] : 18'd0, cyc + 1});
            end
            if (owner < 0) begin
               ptr = (eg + 1) % 3;
               if (lk[eg]) begin owner = eg; beats = 1; idle = 0; end
            end else begin
               beats++;
               idle = 0;
               if (!lk[eg] || beats == 16) begin ptr = (owner + 1) % 3; owner = -1; end
            end
         end else begin
            chk("idle_cs", sram_cs, 0);
            chk("idle_web", sram_web, 1);
            chk("hold_addr", sram_addr, last_addr);
            chk("hold_wdata", sram_wdata, last_wdata);
            if (owner >= 0) begin
               idle++;
               if (idle == 8) begin ptr = (owner + 1) % 3; owner = -1; end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      v = '0; wr = '0; lk = '0;
   endtask

   task automatic do_reset();
      step();
      rst_n = 1'b0;
      quiet();
      step();
      step();
      rst_n = 1'b1;
   endtask

   function automatic logic [16:0] pick_addr();
      int r;
      r = $urandom_range(0, 19);
      case (r)
         16:      return 17'd32767;
         17:      return 17'd32768;
         18:      return 17'h10000;
         19:      return 17'h1FFFF;
         default: return 17'(r);
      endcase
   endfunction

   task automatic rand_cycles(input int n, input int pv);
      for (int i = 0; i < n; i++) begin
         for (int m = 0; m < 3; m++) begin
            v[m]  = ($urandom_range(0, 9) < pv);
            wr[m] = 1'($urandom_range(0, 1));
            lk[m] = ($urandom_range(0, 9) < 8);
            a[m]  = pick_addr();
            wd[m] = 18'($urandom);
         end
         step();
      end
      quiet();
   endtask

   int dma_cnt, n;
   bit found;

   initial begin
      for (int i = 0; i < 32768; i++) begin
         sram_mem[i] = 18'((i * 37) ^ 18'h2A5A5);
         ref_mem[i]  = 18'((i * 37) ^ 18'h2A5A5);
      end
      for (int m = 0; m < 3; m++) begin a[m] = 17'(m); wd[m] = '0; end
      rst_n = 1'b0;
      v = 3'b111; wr = '0; lk = '0;
      repeat (3) step();
      rst_n = 1'b1;

      // Round robin with all three reading continuously.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rr_order", req_ready, 64'(1) << (i % 3));
         @(posedge clk); #1;
         for (int m = 0; m < 3; m++) a[m] = 17'($urandom_range(0, 15));
      end
      quiet();

      // Burst cap: DMA locked writes against a waiting PE.
      do_reset();
      v = 3'b011; wr = 3'b001; lk = 3'b001;
      a[0] = 17'd4; wd[0] = 18'h1234; a[1] = 17'd5;
      dma_cnt = 0; found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (req_ready[1]) found = 1;
         else begin
            if (req_ready[0]) dma_cnt++;
            @(posedge clk); #1;
            a[0] = 17'($urandom_range(0, 15)); wd[0] = 18'($urandom);
         end
      end
      chk("burst_len", dma_cnt, 16);
      @(posedge clk); #1;
      @(negedge clk);
      chk("burst_resume", req_ready, 3'b001);
      step();
      quiet();
      repeat (10) step();

      // Idle timeout: owner locks then goes silent.
      do_reset();
      v = 3'b001; wr = 3'b001; lk = 3'b001; a[0] = 17'd3; wd[0] = 18'h0ABC;
      step();
      v = 3'b010; wr = '0; lk = '0; a[1] = 17'd3;
      n = 0; found = 0;
      for (int i = 1; i <= 20 && !found; i++) begin
         @(negedge clk);
         n = i;
         if (req_ready[1]) found = 1;
         else begin @(posedge clk); #1; end
      end
      chk("idle_timeout", n, 9);
      step();
      quiet();
      step();

      // Out-of-range read then write from the debug port.
      do_reset();
      v = 3'b100; wr = 3'b000; a[2] = 17'h10000;
      step();
      wr = 3'b100; wd[2] = 18'h3FFFF;
      step();
      quiet();
      repeat (2) step();

      // Reset in the cycle after a read is accepted.
      do_reset();
      v = 3'b010; wr = '0; a[1] = 17'd7;
      step();
      rst_n = 1'b0;
      quiet();
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();

      rand_cycles(800, 6);
      do_reset();
      rand_cycles(800, 3);
      rand_cycles(300, 9);

      quiet();
      repeat (4) step();
      chk("rsp_drain", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
